// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one unified instruction/data memory between the core (C) and a DMA loader (D).
// Accesses are serialised IDLE -> ISSUE -> WAIT -> DONE; round-robin on simultaneous requests.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic          grant_dma;

    // DMA wins only when the core is idle or the core was the last owner.
    assign grant_dma = dma_req & (~cpu_req | ~owner_q);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d = grant_dma;
                    we_d    = grant_dma ? dma_we    : cpu_we;
                    addr_d  = grant_dma ? dma_addr  : cpu_addr;
                    wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = WAIT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            dma_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= 4'd0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // All strobes decode straight from the registered state, so they are one cycle wide by construction.
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = (state_q == ISSUE) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state_q == DONE) & ~owner_q;
    assign dma_ack   = (state_q == DONE) & owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses MEM_LAT=2, instance 1 uses MEM_LAT=1.
// A scoreboard queue holds expected accesses in grant order; a monitor checks mem strobes and acks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    typedef struct {
        int          inst;
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          issued;
    } acc_t;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic [31:0] cpu_rdata [2];
    logic        cpu_ack   [2];
    logic        dma_req   [2];
    logic        dma_we    [2];
    logic [31:0] dma_addr  [2];
    logic [31:0] dma_wdata [2];
    logic [31:0] dma_rdata [2];
    logic        dma_ack   [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        owner     [2];
    logic        busy      [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    acc_t        sbq[$];
    logic [31:0] shadow  [2][64];
    logic [31:0] last_rd [2][2];

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 2 : 1;
        logic [31:0] mem [64];
        logic        lat_active;
        logic [3:0]  lat_cnt;
        logic [31:0] lat_data;

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
            mem[4]     = 32'hDEAD_BEEF;
            lat_active = 1'b0;
            lat_cnt    = 4'd0;
            lat_data   = 32'h0;
        end

        // Read data is only valid exactly LAT cycles after the issue cycle.
        always @(posedge clk) begin
            if (lat_active) begin
                if (lat_cnt == 4'd0) lat_active <= 1'b0;
                else lat_cnt <= lat_cnt - 4'd1;
            end
            if (mem_en[gi] === 1'b1) begin
                if (mem_we[gi] === 1'b1) begin
                    mem[mem_addr[gi][7:2]] <= mem_wdata[gi];
                end else begin
                    lat_active <= 1'b1;
                    lat_cnt    <= 4'(LAT - 1);
                    lat_data   <= mem[mem_addr[gi][7:2]];
                end
            end
        end
        assign mem_rdata[gi] = (lat_active && lat_cnt == 4'd0) ? lat_data : 32'hBAD0_BAD0;

        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst[gi]),
            .cpu_req   (cpu_req[gi]),
            .cpu_we    (cpu_we[gi]),
            .cpu_addr  (cpu_addr[gi]),
            .cpu_wdata (cpu_wdata[gi]),
            .cpu_rdata (cpu_rdata[gi]),
            .cpu_ack   (cpu_ack[gi]),
            .dma_req   (dma_req[gi]),
            .dma_we    (dma_we[gi]),
            .dma_addr  (dma_addr[gi]),
            .dma_wdata (dma_wdata[gi]),
            .dma_rdata (dma_rdata[gi]),
            .dma_ack   (dma_ack[gi]),
            .mem_en    (mem_en[gi]),
            .mem_we    (mem_we[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_wdata (mem_wdata[gi]),
            .mem_rdata (mem_rdata[gi]),
            .owner     (owner[gi]),
            .busy      (busy[gi])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] rd_model(input int k, input logic [31:0] a);
        return shadow[k][a[7:2]];
    endfunction

    // Monitor: checks every memory strobe and every ack against the scoreboard front.
    always @(negedge clk) begin
        acc_t        a;
        logic [31:0] rd;
        bit          p;
        for (int k = 0; k < 2; k++) begin
            if (rst[k] === 1'b1) begin
                last_rd[k][0] = 32'h0;
                last_rd[k][1] = 32'h0;
                while (sbq.size() > 0 && sbq[0].inst == k) void'(sbq.pop_front());
            end
            if (mem_we[k] === 1'b1 && mem_en[k] !== 1'b1) flag($sformatf("mem_we_without_en inst%0d", k));
            if (mem_en[k] === 1'b1) begin
                if (sbq.size() == 0 || sbq[0].inst != k || sbq[0].issued) begin
                    flag($sformatf("unexpected_mem_en inst%0d", k));
                end else begin
                    sbq[0].issued = 1'b1;
                    check("mem_addr", mem_addr[k], sbq[0].addr);
                    check("mem_we", 32'(mem_we[k]), 32'(sbq[0].we));
                    if (sbq[0].we) check("mem_wdata", mem_wdata[k], sbq[0].wdata);
                end
            end
            if (cpu_ack[k] === 1'b1 || dma_ack[k] === 1'b1) begin
                check("ack_overlap", 32'(cpu_ack[k] & dma_ack[k]), 32'h0);
                if (sbq.size() == 0 || sbq[0].inst != k) begin
                    flag($sformatf("unexpected_ack inst%0d", k));
                end else begin
                    a  = sbq.pop_front();
                    p  = (dma_ack[k] === 1'b1);
                    rd = p ? dma_rdata[k] : cpu_rdata[k];
                    check("ack_port", 32'(p), 32'(a.port));
                    check("owner_at_ack", 32'(owner[k]), 32'(a.port));
                    check("issued_before_ack", 32'(a.issued), 32'h1);
                    check("ack_rdata", rd, a.we ? last_rd[k][a.port] : a.exp_rd);
                    if (!a.we) last_rd[k][a.port] = a.exp_rd;
                    $display("[TB] inst%0d %s %s addr=%h rdata=%h cycle=%0d", k,
                             a.port ? "DMA" : "CPU", a.we ? "WR" : "RD", a.addr, rd, cyc);
                end
            end
        end
    end

    task automatic start(input int k, input bit p, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
        acc_t a;
        a.inst = k; a.port = p; a.we = we; a.addr = addr; a.wdata = wd;
        a.exp_rd = exp_rd; a.issued = 1'b0;
        if (we) shadow[k][addr[7:2]] = wd;
        sbq.push_back(a);
        if (p) begin
            dma_req[k] = 1'b1; dma_we[k] = we; dma_addr[k] = addr; dma_wdata[k] = wd;
        end else begin
            cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wd;
        end
    endtask

    // Waits for the port's ack (bounded), drops req in the ack cycle, returns the ack cycle.
    task automatic wait_ack(input int k, input bit p, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((p ? dma_ack[k] : cpu_ack[k]) === 1'b1) begin
                at = cyc;
                if (p) dma_req[k] = 1'b0; else cpu_req[k] = 1'b0;
                return;
            end
        end
        flag($sformatf("ack_timeout inst%0d port%0d", k, p));
        if (p) dma_req[k] = 1'b0; else cpu_req[k] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   c0, at, prev;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 4};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'hCAFE_0001, 32'h0,         4};
        vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'hCAFE_0001, 4};
        vecs[3] = '{1'b1, 1'b0, 32'h24, 32'h0,         32'hA500_0009, 4};
        vecs[4] = '{1'b0, 1'b1, 32'h30, 32'h0BAD_F00D, 32'h0,         4};
        vecs[5] = '{1'b1, 1'b0, 32'h30, 32'h0,         32'h0BAD_F00D, 4};
        vecs[6] = '{1'b0, 1'b0, 32'h40, 32'h0,         32'h0000_1234, 4};
        vecs[7] = '{1'b1, 1'b0, 32'h00, 32'h0,         32'hA500_0000, 4};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = 32'h0; cpu_wdata[k] = 32'h0;
            dma_req[k] = 1'b0; dma_we[k] = 1'b0; dma_addr[k] = 32'h0; dma_wdata[k] = 32'h0;
            last_rd[k][0] = 32'h0; last_rd[k][1] = 32'h0;
            for (int i = 0; i < 64; i++) shadow[k][i] = 32'hA500_0000 | i;
            shadow[k][4] = 32'hDEAD_BEEF;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(busy[0]), 32'h0);
        check("rst_mem_en", 32'(mem_en[0]), 32'h0);
        check("rst_mem_we", 32'(mem_we[0]), 32'h0);
        check("rst_cpu_ack", 32'(cpu_ack[0]), 32'h0);
        check("rst_dma_ack", 32'(dma_ack[0]), 32'h0);
        check("rst_cpu_rdata", cpu_rdata[0], 32'h0);
        check("rst_dma_rdata", dma_rdata[0], 32'h0);
        check("rst_mem_addr", mem_addr[0], 32'h0);
        check("rst_mem_wdata", mem_wdata[0], 32'h0);
        check("rst_owner", 32'(owner[0]), 32'h1);
        check("rst_owner_i1", 32'(owner[1]), 32'h1);

        // Simultaneous first requests: core wins the tie, DMA write follows
        @(posedge clk); #1;
        c0 = cyc;
        start(0, 1'b0, 1'b0, 32'h0, 32'h0, rd_model(0, 32'h0));
        start(0, 1'b1, 1'b1, 32'h40, 32'h1234, 32'h0);
        check("sim_busy_idle", 32'(busy[0]), 32'h0);
        wait_ack(0, 1'b0, at);
        check("sim_cpu_ack_cycle", at, c0 + 4);
        wait_ack(0, 1'b1, at);
        check("sim_dma_ack_cycle", at, c0 + 9);

        // Table of single-port accesses
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            c0 = cyc;
            start(0, vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rd);
            wait_ack(0, vecs[v].port, at);
            check($sformatf("vec%0d_latency", v), at - c0, vecs[v].exp_lat);
        end
        @(negedge clk);
        check("cpu_rdata_held", cpu_rdata[0], 32'h0000_1234);

        // Both ports continuously requesting: C,D,C,D,C,D with MEM_LAT+3 spacing
        @(posedge clk); #1;
        c0 = cyc;
        prev = c0;
        start(0, 1'b0, 1'b0, 32'h44, 32'h0, rd_model(0, 32'h44));
        start(0, 1'b1, 1'b0, 32'h48, 32'h0, rd_model(0, 32'h48));
        for (int i = 0; i < 3; i++) begin
            wait_ack(0, 1'b0, at);
            check("fair_c_cycle", at, (i == 0) ? c0 + 4 : prev + 5);
            prev = at;
            if (i < 2) start(0, 1'b0, 1'b0, 32'h44, 32'h0, rd_model(0, 32'h44));
            wait_ack(0, 1'b1, at);
            check("fair_d_cycle", at, prev + 5);
            prev = at;
            if (i < 2) start(0, 1'b1, 1'b0, 32'h48, 32'h0, rd_model(0, 32'h48));
        end

        // Payload change after grant is ignored
        @(posedge clk); #1;
        c0 = cyc;
        start(0, 1'b0, 1'b0, 32'h10, 32'h0, rd_model(0, 32'h10));
        repeat (2) @(posedge clk);
        #1 cpu_addr[0] = 32'h20;
        check("payload_mem_addr_wait", mem_addr[0], 32'h10);
        wait_ack(0, 1'b0, at);
        check("payload_latency", at - c0, 4);
        check("payload_mem_addr", mem_addr[0], 32'h10);

        // Reset in WAIT abandons the access
        @(posedge clk); #1;
        start(0, 1'b0, 1'b0, 32'h14, 32'h0, rd_model(0, 32'h14));
        repeat (2) @(posedge clk);
        #1;
        check("rst_wait_busy_before", 32'(busy[0]), 32'h1);
        rst[0] = 1'b1;
        cpu_req[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check("rstw_busy", 32'(busy[0]), 32'h0);
        check("rstw_cpu_ack", 32'(cpu_ack[0]), 32'h0);
        check("rstw_mem_en", 32'(mem_en[0]), 32'h0);
        check("rstw_cpu_rdata", cpu_rdata[0], 32'h0);
        check("rstw_dma_rdata", dma_rdata[0], 32'h0);
        check("rstw_owner", 32'(owner[0]), 32'h1);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        c0 = cyc;
        start(0, 1'b0, 1'b0, 32'h10, 32'h0, rd_model(0, 32'h10));
        wait_ack(0, 1'b0, at);
        check("after_rst_latency", at - c0, 4);
        check("after_rst_rdata", cpu_rdata[0], 32'hDEAD_BEEF);

        // MEM_LAT=1: store then load through the core
        @(posedge clk); #1;
        c0 = cyc;
        start(1, 1'b0, 1'b1, 32'h8, 32'h55, 32'h0);
        wait_ack(1, 1'b0, at);
        check("lat1_sw_latency", at - c0, 3);
        @(posedge clk); #1;
        c0 = cyc;
        start(1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h55);
        wait_ack(1, 1'b0, at);
        check("lat1_lw_latency", at - c0, 3);
        check("lat1_cpu_rdata", cpu_rdata[1], 32'h55);
        check("lat1_dma_rdata", dma_rdata[1], 32'h0);

        repeat (3) @(negedge clk);
        check("sb_drained", sbq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
